// File: rtl/lcd_pkg.sv
// lcd_pkg: shared control-bit indices, timer codes, translator bit positions and executor states
package lcd_pkg;
    localparam int CTL_DONE  = 0;
    localparam int CTL_EXEC  = 1;
    localparam int CTL_ERROR = 2;
    localparam int CTL_NO_BF = 3;
    localparam logic [3:0] TMR_BF_READ = 4'b0100;
    localparam int TR_E  = 0;
    localparam int TR_RW = 1;
    localparam int TR_RS = 2;
    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_CLR_EXEC, S_PROG_CMD, S_WAIT_CMD, S_CAPTURE,
        S_PROG_BF, S_WAIT_BF, S_CHECK_BF, S_NEXT, S_WRITEBACK
    } state_t;
endpackage

// File: rtl/poll_counter.sv
// poll_counter: busy-flag poll counter with synchronous clear and limit compare
module poll_counter #(
    parameter int MAX_POLLS = 255
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam int PW = $clog2(MAX_POLLS + 1);
    logic [PW-1:0] cnt;
    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + PW'(1);
    assign at_limit = cnt >= PW'(MAX_POLLS);
endmodule

// File: rtl/ejecutador_lcd_param.sv
// ejecutador_lcd_param: runs one host command through translator and LCD timer, then writes status/data back
module ejecutador_lcd_param
    import lcd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_INSTR = 4,
    parameter int MAX_POLLS = 255,
    parameter int BF_BIT    = 7,
    localparam int IW = MAX_INSTR > 1 ? $clog2(MAX_INSTR) : 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_reg_control,
    input  logic [DATA_W-1:0] i_reg_datos,
    output logic [DATA_W-1:0] o_in2_reg_control,
    output logic              o_wr2_reg_control,
    output logic [DATA_W-1:0] o_in2_reg_datos,
    output logic              o_wr2_reg_datos,
    input  logic              i_ready_traductor,
    input  logic [2:0]        i_control_traductor,
    input  logic [7:0]        i_dato_traductor,
    output logic              o_enable_traductor_bar,
    output logic [IW-1:0]     o_contador_instruccion_traductor,
    input  logic              i_ready_temporizador,
    output logic              o_program_temporizador,
    output logic [3:0]        o_control_temporizador,
    output logic [7:0]        o_dato_temporizador,
    input  logic [7:0]        i_dato_router,
    output logic              o_direccion_router
);
    state_t state, state_n;
    logic [DATA_W-1:0] ctl_lat, ctl_lat_n, dat, dat_n, acc, acc_n, ctl_clr, ctl_done;
    logic [DATA_W-1:0] in2_ctl_n, in2_dat_n;
    logic rd_seen, rd_seen_n, err, err_n, bf, bf_n;
    logic [IW-1:0] idx_n;
    logic en_bar_n, dir_n, prog_n, wr_ctl_n, wr_dat_n, poll_clr, poll_inc, poll_max, tmr_go, last;
    logic [3:0] ctl_tmr_n;
    logic [7:0] dato_tmr_n;

    poll_counter #(.MAX_POLLS(MAX_POLLS)) u_poll (
        .clk(clk), .i_rst_n(i_rst_n), .clr(poll_clr), .inc(poll_inc), .at_limit(poll_max)
    );

    assign ctl_clr  = ctl_lat & ~((DATA_W'(1) << CTL_DONE) | (DATA_W'(1) << CTL_EXEC) | (DATA_W'(1) << CTL_ERROR));
    assign ctl_done = ctl_clr | (DATA_W'(1) << CTL_DONE) | (DATA_W'(err) << CTL_ERROR);
    // The program pulse is still high in the first wait cycle, before the timer has reacted.
    assign tmr_go   = i_ready_temporizador && !o_program_temporizador;
    assign last     = o_contador_instruccion_traductor == IW'(MAX_INSTR - 1);

    always_comb begin
        state_n    = state;
        ctl_lat_n  = ctl_lat;
        dat_n      = dat;
        acc_n      = acc;
        rd_seen_n  = rd_seen;
        err_n      = err;
        bf_n       = bf;
        idx_n      = o_contador_instruccion_traductor;
        en_bar_n   = o_enable_traductor_bar;
        dir_n      = o_direccion_router;
        ctl_tmr_n  = o_control_temporizador;
        dato_tmr_n = o_dato_temporizador;
        in2_ctl_n  = o_in2_reg_control;
        in2_dat_n  = o_in2_reg_datos;
        prog_n     = 1'b0;
        wr_ctl_n   = 1'b0;
        wr_dat_n   = 1'b0;
        poll_clr   = 1'b0;
        poll_inc   = 1'b0;
        case (state)
            S_IDLE: state_n = i_reg_control[CTL_EXEC] ? S_LATCH : S_IDLE;
            S_LATCH: begin
                ctl_lat_n = i_reg_control;
                dat_n     = i_reg_datos;
                acc_n     = '0;
                rd_seen_n = 1'b0;
                err_n     = 1'b0;
                poll_clr  = 1'b1;
                state_n   = S_CLR_EXEC;
            end
            S_CLR_EXEC: begin
                in2_ctl_n = ctl_clr;
                wr_ctl_n  = 1'b1;
                en_bar_n  = 1'b0;
                idx_n     = '0;
                state_n   = S_PROG_CMD;
            end
            S_PROG_CMD: begin
                ctl_tmr_n  = {i_control_traductor, 1'b0};
                dato_tmr_n = i_dato_traductor;
                prog_n     = 1'b1;
                state_n    = S_WAIT_CMD;
            end
            S_WAIT_CMD: if (tmr_go) begin
                dir_n   = o_control_temporizador[TR_RW+1];
                state_n = o_control_temporizador[TR_RW+1] ? S_CAPTURE : ctl_lat[CTL_NO_BF] ? S_NEXT : S_PROG_BF;
            end
            S_CAPTURE: begin
                acc_n     = {acc[DATA_W-9:0], i_dato_router};
                rd_seen_n = 1'b1;
                dir_n     = 1'b0;
                state_n   = S_NEXT;
            end
            S_PROG_BF: begin
                ctl_tmr_n  = TMR_BF_READ;
                dato_tmr_n = '0;
                dir_n      = 1'b1;
                prog_n     = 1'b1;
                poll_inc   = 1'b1;
                state_n    = S_WAIT_BF;
            end
            S_WAIT_BF: if (tmr_go) begin
                bf_n    = i_dato_router[BF_BIT];
                dir_n   = 1'b0;
                state_n = S_CHECK_BF;
            end
            S_CHECK_BF: begin
                err_n   = err | (bf && poll_max);
                state_n = !bf ? S_NEXT : !poll_max ? S_PROG_BF : S_WRITEBACK;
            end
            S_NEXT: begin
                poll_clr = 1'b1;
                err_n    = err | (i_ready_traductor && last);
                idx_n    = (i_ready_traductor && !last) ? o_contador_instruccion_traductor + IW'(1) : o_contador_instruccion_traductor;
                state_n  = (i_ready_traductor && !last) ? S_PROG_CMD : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                in2_ctl_n = ctl_done;
                in2_dat_n = rd_seen ? acc : dat;
                wr_ctl_n  = 1'b1;
                wr_dat_n  = 1'b1;
                en_bar_n  = 1'b1;
                idx_n     = '0;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state                            <= S_IDLE;
            ctl_lat                          <= '0;
            dat                              <= '0;
            acc                              <= '0;
            rd_seen                          <= 1'b0;
            err                              <= 1'b0;
            bf                               <= 1'b0;
            o_contador_instruccion_traductor <= '0;
            o_enable_traductor_bar           <= 1'b1;
            o_direccion_router               <= 1'b0;
            o_control_temporizador           <= '0;
            o_dato_temporizador              <= '0;
            o_program_temporizador           <= 1'b0;
            o_in2_reg_control                <= '0;
            o_wr2_reg_control                <= 1'b0;
            o_in2_reg_datos                  <= '0;
            o_wr2_reg_datos                  <= 1'b0;
        end else begin
            state                            <= state_n;
            ctl_lat                          <= ctl_lat_n;
            dat                              <= dat_n;
            acc                              <= acc_n;
            rd_seen                          <= rd_seen_n;
            err                              <= err_n;
            bf                               <= bf_n;
            o_contador_instruccion_traductor <= idx_n;
            o_enable_traductor_bar           <= en_bar_n;
            o_direccion_router               <= dir_n;
            o_control_temporizador           <= ctl_tmr_n;
            o_dato_temporizador              <= dato_tmr_n;
            o_program_temporizador           <= prog_n;
            o_in2_reg_control                <= in2_ctl_n;
            o_wr2_reg_control                <= wr_ctl_n;
            o_in2_reg_datos                  <= in2_dat_n;
            o_wr2_reg_datos                  <= wr_dat_n;
        end
endmodule

// File: tb/tb_ejecutador_lcd_param.sv
// tb_ejecutador_lcd_param: table-driven bench with translator, timer and router models around the executor
module tb_ejecutador_lcd_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     ctl;
        logic [31:0]     datos;
        logic [2:0]      n;
        logic            stuck;
        logic [7:0]      busy;
        logic [3:0][2:0] ictl;
        logic [3:0][7:0] idat;
        logic [3:0][7:0] rd;
        logic [31:0]     exp_ctl;
        logic [31:0]     exp_dat;
        logic [7:0]      exp_prog;
        logic [7:0]      exp_bf;
        logic [7:0]      exp_first;
    } vec_t;

    vec_t cur = '0;
    vec_t tab [6];
    logic [31:0] reg_control = '0, reg_datos = '0;
    logic [31:0] in2_ctl, in2_dat;
    logic wr_ctl, wr_dat, rdy_tr, en_bar, rdy_tmr, prog, dir;
    logic [2:0] ctl_tr;
    logic [7:0] dat_tr, dato_tmr, dato_rt;
    logic [1:0] idx;
    logic [3:0] ctl_tmr;
    int checks = 0, errors = 0;

    ejecutador_lcd_param #(.DATA_W(32), .MAX_INSTR(4), .MAX_POLLS(3), .BF_BIT(7)) dut (
        .clk(clk), .i_rst_n(rst_n),
        .i_reg_control(reg_control), .i_reg_datos(reg_datos),
        .o_in2_reg_control(in2_ctl), .o_wr2_reg_control(wr_ctl),
        .o_in2_reg_datos(in2_dat), .o_wr2_reg_datos(wr_dat),
        .i_ready_traductor(rdy_tr), .i_control_traductor(ctl_tr), .i_dato_traductor(dat_tr),
        .o_enable_traductor_bar(en_bar), .o_contador_instruccion_traductor(idx),
        .i_ready_temporizador(rdy_tmr), .o_program_temporizador(prog),
        .o_control_temporizador(ctl_tmr), .o_dato_temporizador(dato_tmr),
        .i_dato_router(dato_rt), .o_direccion_router(dir)
    );

    // Environment models: translator table, fixed-latency timer, router returning busy or read bytes.
    int tcnt = 0, bf_base = 0;
    int n_prog = 0, n_bf = 0, n_cmd = 0, n_wr_ctl = 0, n_wr_dat = 0, n_done = 0;
    logic [31:0] last_ctl = '0, done_ctl = '0, last_dat = '0;
    logic done_both = 1'b0;
    logic [7:0] cmd_log [256];

    assign ctl_tr  = cur.ictl[idx];
    assign dat_tr  = cur.idat[idx];
    assign rdy_tr  = cur.stuck || ({1'b0, idx} < cur.n - 3'd1);
    assign rdy_tmr = tcnt == 0;
    assign dato_rt = (ctl_tmr == 4'b0100) ? ((n_bf - bf_base <= int'(cur.busy)) ? 8'h80 : 8'h00) : cur.rd[idx];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tcnt <= 0;
        else if (prog) tcnt <= 3;
        else if (tcnt != 0) tcnt <= tcnt - 1;

    always @(posedge clk) begin
        if (prog) begin
            n_prog <= n_prog + 1;
            if (ctl_tmr == 4'b0100) n_bf <= n_bf + 1;
            else begin
                cmd_log[n_cmd[7:0]] <= dato_tmr;
                n_cmd <= n_cmd + 1;
            end
        end
        if (wr_ctl) begin
            n_wr_ctl <= n_wr_ctl + 1;
            last_ctl <= in2_ctl;
            if (in2_ctl[0]) begin
                n_done    <= n_done + 1;
                done_ctl  <= in2_ctl;
                done_both <= wr_dat;
            end
        end
        if (wr_dat) begin
            n_wr_dat <= n_wr_dat + 1;
            last_dat <= in2_dat;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int k);
        int b_prog, b_bf, b_ctl, b_done, b_cmd;
        cur = v;
        reg_datos = v.datos;
        b_prog = n_prog; b_bf = n_bf; bf_base = n_bf; b_ctl = n_wr_ctl; b_done = n_done; b_cmd = n_cmd;
        reg_control = v.ctl;
        for (int i = 0; i < 50 && n_wr_ctl == b_ctl; i++) @(negedge clk);
        chk($sformatf("v%0d clear_strobe", k), 32'(n_wr_ctl - b_ctl), 32'd1);
        chk($sformatf("v%0d clear_value", k), last_ctl, v.ctl & ~32'h7);
        reg_control = last_ctl;
        for (int i = 0; i < 3000 && n_done == b_done; i++) @(negedge clk);
        chk($sformatf("v%0d done_strobe", k), 32'(n_done - b_done), 32'd1);
        chk($sformatf("v%0d wb_control", k), done_ctl, v.exp_ctl);
        chk($sformatf("v%0d wb_both", k), 32'(done_both), 32'd1);
        chk($sformatf("v%0d wb_datos", k), last_dat, v.exp_dat);
        chk($sformatf("v%0d programs", k), 32'(n_prog - b_prog), 32'(v.exp_prog));
        chk($sformatf("v%0d bf_programs", k), 32'(n_bf - b_bf), 32'(v.exp_bf));
        chk($sformatf("v%0d first_dato", k), 32'(cmd_log[b_cmd[7:0]]), 32'(v.exp_first));
        reg_control = done_ctl;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int b_bf, b_wc, b_wd;
        tab[0] = '{ctl: 32'h0000_000A, datos: 32'hDEAD_BEEF, n: 3'd1, stuck: 1'b0, busy: 8'd0,
                   ictl: {3'd0, 3'd0, 3'd0, 3'b001}, idat: {8'h0, 8'h0, 8'h0, 8'h38}, rd: '0,
                   exp_ctl: 32'h0000_0009, exp_dat: 32'hDEAD_BEEF, exp_prog: 8'd1, exp_bf: 8'd0, exp_first: 8'h38};
        tab[1] = '{ctl: 32'h0000_0002, datos: 32'h1234_5678, n: 3'd1, stuck: 1'b0, busy: 8'd2,
                   ictl: {3'd0, 3'd0, 3'd0, 3'b001}, idat: {8'h0, 8'h0, 8'h0, 8'h01}, rd: '0,
                   exp_ctl: 32'h0000_0001, exp_dat: 32'h1234_5678, exp_prog: 8'd4, exp_bf: 8'd3, exp_first: 8'h01};
        tab[2] = '{ctl: 32'hA500_0002, datos: 32'h0000_0000, n: 3'd1, stuck: 1'b0, busy: 8'd99,
                   ictl: {3'd0, 3'd0, 3'd0, 3'b001}, idat: {8'h0, 8'h0, 8'h0, 8'h0F}, rd: '0,
                   exp_ctl: 32'hA500_0005, exp_dat: 32'h0000_0000, exp_prog: 8'd4, exp_bf: 8'd3, exp_first: 8'h0F};
        tab[3] = '{ctl: 32'h0000_000A, datos: 32'hFFFF_FFFF, n: 3'd3, stuck: 1'b0, busy: 8'd0,
                   ictl: {3'd0, 3'b110, 3'b110, 3'b110}, idat: {8'h0, 8'hA3, 8'hA2, 8'hA1},
                   rd: {8'h0, 8'h33, 8'h22, 8'h11},
                   exp_ctl: 32'h0000_0009, exp_dat: 32'h0011_2233, exp_prog: 8'd3, exp_bf: 8'd0, exp_first: 8'hA1};
        tab[4] = '{ctl: 32'h0000_000A, datos: 32'h5555_AAAA, n: 3'd4, stuck: 1'b1, busy: 8'd0,
                   ictl: {4{3'b001}}, idat: {8'h0C, 8'h06, 8'h01, 8'h38}, rd: '0,
                   exp_ctl: 32'h0000_000D, exp_dat: 32'h5555_AAAA, exp_prog: 8'd4, exp_bf: 8'd0, exp_first: 8'h38};
        tab[5] = '{ctl: 32'h0000_0002, datos: 32'hCAFE_0000, n: 3'd2, stuck: 1'b0, busy: 8'd0,
                   ictl: {3'd0, 3'd0, 3'b110, 3'b001}, idat: {8'h0, 8'h0, 8'h0C, 8'h28},
                   rd: {8'h0, 8'h0, 8'h77, 8'h00},
                   exp_ctl: 32'h0000_0001, exp_dat: 32'h0000_0077, exp_prog: 8'd3, exp_bf: 8'd1, exp_first: 8'h28};
        repeat (2) @(negedge clk);
        chk("rst en_bar", 32'(en_bar), 32'd1);
        chk("rst strobes", {24'd0, prog, wr_ctl, wr_dat, dir, idx, 2'b00}, 32'd0);
        chk("rst ctl_tmr", {20'd0, ctl_tmr, dato_tmr}, 32'd0);
        chk("rst in2_ctl", in2_ctl, 32'd0);
        chk("rst in2_dat", in2_dat, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) run(tab[k], k);
        // Abort during a busy-flag wait.
        cur = tab[2];
        b_bf = n_bf;
        bf_base = n_bf;
        reg_control = 32'h0000_0002;
        for (int i = 0; i < 200 && n_bf == b_bf; i++) @(negedge clk);
        chk("midrst dir_before", 32'(dir), 32'd1);
        chk("midrst en_before", 32'(en_bar), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst en_bar", 32'(en_bar), 32'd1);
        chk("midrst dir", 32'(dir), 32'd0);
        b_wc = n_wr_ctl;
        b_wd = n_wr_dat;
        reg_control = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst no_wr_ctl", 32'(n_wr_ctl - b_wc), 32'd0);
        chk("midrst no_wr_dat", 32'(n_wr_dat - b_wd), 32'd0);
        run(tab[0], 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
